// File: rtl/stopwatch_time_counter.sv
// Stopwatch time counter: MM:SS.cc BCD counter fed by the divided 100 Hz tick, with lap hold and clear.
// Latency: a tick_in rise sampled at edge N appears on the digit outputs after edge N+1; lap/clear likewise.
// Backpressure: none; the block consumes at most one tick rise per 2 clk cycles and never stalls.
//
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   tick_in                           divided square wave; one count per rising edge
//   clear                             one-cycle pulse; zero live and lap values, return to LIVE
//   lap                               one-cycle pulse; toggle between LIVE and HOLD display
//   cs_*/s_*/m_* [3:0]                displayed digits, BCD, registered
//   lap_active                        high while the held lap value is displayed
//   wrap_pulse                        one-cycle pulse when a rise arrives at 59:59.99
module stopwatch_time_counter #(
    parameter bit HOLD_ON_WRAP = 1'b0    // 0: wrap to 00:00.00, 1: saturate at 59:59.99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] cs_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] s_ones,
    output logic [3:0] s_tens,
    output logic [3:0] m_ones,
    output logic [3:0] m_tens,
    output logic       lap_active,
    output logic       wrap_pulse
);

    typedef enum logic {
        ST_LIVE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Packed digit order, LSB first: cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens.
    localparam logic [23:0] TERM_COUNT = 24'h595999;

    state_t      state;
    logic        tick_d;
    logic        seen_low;   // tick_in has been sampled low since reset
    logic        rise;
    logic [23:0] live;
    logic [23:0] live_nx;
    logic [23:0] lap_reg;
    logic        at_term;
    logic        wrap_hit;
    logic        wrap_q;     // wrap detected alongside the live update; delayed to line up with digits

    // One BCD digit step: returns {carry_out, next_digit}. A digit at (or, defensively,
    // beyond) its maximum returns to 0 and carries, so no illegal code can persist.
    function automatic logic [4:0] bcd_step(input logic [3:0] d,
                                            input logic [3:0] dmax,
                                            input logic       cin);
        logic [3:0] q;
        logic       co;
        q  = d;
        co = 1'b0;
        if (cin) begin
            if (d >= dmax) begin
                q  = 4'd0;
                co = 1'b1;
            end else begin
                q = d + 4'd1;
            end
        end
        return {co, q};
    endfunction

    // Without seen_low, a tick_in already high at reset release would look like a
    // fresh rise (tick_d resets to 0) and produce a spurious count.
    assign rise     = tick_in & ~tick_d & seen_low;
    assign at_term  = (live == TERM_COUNT);
    assign wrap_hit = rise & at_term;

    always_comb begin
        logic       carry;
        logic [4:0] st;
        logic [3:0] dmax;
        live_nx = live;
        carry   = rise;
        st      = 5'd0;
        dmax    = 4'd9;
        for (int i = 0; i < 6; i++) begin
            // Seconds tens and minutes tens count 0-5; all other digits 0-9.
            dmax = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            st   = bcd_step(live[i*4 +: 4], dmax, carry);
            live_nx[i*4 +: 4] = st[3:0];
            carry = st[4];
        end
        if (HOLD_ON_WRAP && wrap_hit) begin
            live_nx = live;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_LIVE;
            tick_d     <= 1'b0;
            seen_low   <= 1'b0;
            live       <= '0;
            lap_reg    <= '0;
            wrap_q     <= 1'b0;
            cs_ones    <= 4'd0;
            cs_tens    <= 4'd0;
            s_ones     <= 4'd0;
            s_tens     <= 4'd0;
            m_ones     <= 4'd0;
            m_tens     <= 4'd0;
            lap_active <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            tick_d <= tick_in;
            if (!tick_in) begin
                seen_low <= 1'b1;
            end

            // Clear wins over rise, lap and wrap; the rise it swallows is still
            // consumed by the edge detector so it does not count later.
            if (clear) begin
                live    <= '0;
                lap_reg <= '0;
                state   <= ST_LIVE;
                wrap_q  <= 1'b0;
            end else begin
                live   <= live_nx;
                wrap_q <= wrap_hit;
                if (lap) begin
                    case (state)
                        ST_LIVE: begin
                            // Capture the post-increment value so a lap coincident
                            // with a tick includes that tick.
                            lap_reg <= live_nx;
                            state   <= ST_HOLD;
                        end
                        ST_HOLD: begin
                            state <= ST_LIVE;
                        end
                        default: begin
                            state <= ST_LIVE;
                        end
                    endcase
                end
            end

            // Output stage: one register behind the live/lap state.
            if (state == ST_HOLD) begin
                {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones} <= lap_reg;
            end else begin
                {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones} <= live;
            end
            lap_active <= (state == ST_HOLD);
            wrap_pulse <= wrap_q;
        end
    end

endmodule

// File: tb/tb_stopwatch_time_counter.sv
module tb_stopwatch_time_counter;

    logic clk;
    logic rst;
    logic tick_in;
    logic clear;
    logic lap;

    logic [3:0] cs_ones0, cs_tens0, s_ones0, s_tens0, m_ones0, m_tens0;
    logic [3:0] cs_ones1, cs_tens1, s_ones1, s_tens1, m_ones1, m_tens1;
    logic       lap_active0, wrap_pulse0, lap_active1, wrap_pulse1;

    int checks = 0;
    int errors = 0;
    int wp0 = 0;
    int wp1 = 0;

    stopwatch_time_counter #(.HOLD_ON_WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .clear(clear), .lap(lap),
        .cs_ones(cs_ones0), .cs_tens(cs_tens0), .s_ones(s_ones0), .s_tens(s_tens0),
        .m_ones(m_ones0), .m_tens(m_tens0), .lap_active(lap_active0), .wrap_pulse(wrap_pulse0)
    );

    stopwatch_time_counter #(.HOLD_ON_WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .tick_in(tick_in), .clear(clear), .lap(lap),
        .cs_ones(cs_ones1), .cs_tens(cs_tens1), .s_ones(s_ones1), .s_tens(s_tens1),
        .m_ones(m_ones1), .m_tens(m_tens1), .lap_active(lap_active1), .wrap_pulse(wrap_pulse1)
    );

    wire [23:0] disp0 = {m_tens0, m_ones0, s_tens0, s_ones0, cs_tens0, cs_ones0};
    wire [23:0] disp1 = {m_tens1, m_ones1, s_tens1, s_ones1, cs_tens1, cs_ones1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wrap_pulse0 === 1'b1) wp0++;
        if (wrap_pulse1 === 1'b1) wp1++;
    end

    typedef struct {
        string       name;
        int          rises;
        bit          lap_p;
        bit          clr_p;
        logic [23:0] exp_disp;
        logic        exp_lap;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_both(input string nm, input logic [23:0] exp_d, input logic exp_l);
        chk({nm, " disp0"}, {8'h0, disp0}, {8'h0, exp_d});
        chk({nm, " disp1"}, {8'h0, disp1}, {8'h0, exp_d});
        chk({nm, " lap0"}, {31'h0, lap_active0}, {31'h0, exp_l});
        chk({nm, " lap1"}, {31'h0, lap_active1}, {31'h0, exp_l});
    endtask

    task automatic rises(input int n, input int hi, input int lo);
        for (int k = 0; k < n; k++) begin
            tick_in = 1'b1;
            repeat (hi) @(negedge clk);
            tick_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Jump the live count to a value far into the run without ticking through it.
    task automatic preload(input logic [23:0] v);
        force dut0.live = v;
        force dut1.live = v;
        @(negedge clk);
        release dut0.live;
        release dut1.live;
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"r100",      100, 1'b0, 1'b0, 24'h000100, 1'b0};
        vecs[1] = '{"r1234",    1134, 1'b0, 1'b0, 24'h001234, 1'b0};
        vecs[2] = '{"lap_on",      0, 1'b1, 1'b0, 24'h001234, 1'b1};
        vecs[3] = '{"hold50",     50, 1'b0, 1'b0, 24'h001234, 1'b1};
        vecs[4] = '{"lap_off",     0, 1'b1, 1'b0, 24'h001284, 1'b0};
        vecs[5] = '{"r5more",      5, 1'b0, 1'b0, 24'h001289, 1'b0};
        vecs[6] = '{"clear",       0, 1'b0, 1'b1, 24'h000000, 1'b0};
        vecs[7] = '{"after_clr",   1, 1'b0, 1'b0, 24'h000001, 1'b0};

        rst = 1'b0; tick_in = 1'b0; clear = 1'b0; lap = 1'b0;
        repeat (3) @(negedge clk);
        chk_both("reset", 24'h000000, 1'b0);
        chk("reset wrap0", {31'h0, wrap_pulse0}, 32'h0);
        chk("reset wrap1", {31'h0, wrap_pulse1}, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            rises(vecs[i].rises, 3, 3);
            if (vecs[i].lap_p) pulse_lap();
            if (vecs[i].clr_p) pulse_clear();
            chk_both(vecs[i].name, vecs[i].exp_disp, vecs[i].exp_lap);
            if (i == 0) begin
                chk("no wrap in 100 rises", wp0 + wp1, 0);
            end
        end

        // 00:59.99 -> 01:00.00 with exact latency
        pulse_clear();
        rises(5999, 1, 1);
        repeat (2) @(negedge clk);
        chk_both("preload5999", 24'h005999, 1'b0);
        tick_in = 1'b1;
        @(negedge clk);
        chk("latency edgeN", {8'h0, disp0}, {8'h0, 24'h005999});
        @(negedge clk);
        chk("latency edgeN1", {8'h0, disp0}, {8'h0, 24'h010000});
        tick_in = 1'b0;
        repeat (2) @(negedge clk);

        // Terminal count, both wrap modes
        preload(24'h595999);
        chk_both("at_term", 24'h595999, 1'b0);
        wp0 = 0; wp1 = 0;
        tick_in = 1'b1;
        @(negedge clk);
        chk("wrap early0", {31'h0, wrap_pulse0}, 32'h0);
        @(negedge clk);
        chk("wrap disp0", {8'h0, disp0}, {8'h0, 24'h000000});
        chk("wrap disp1", {8'h0, disp1}, {8'h0, 24'h595999});
        chk("wrap pulse0", {31'h0, wrap_pulse0}, 32'h1);
        chk("wrap pulse1", {31'h0, wrap_pulse1}, 32'h1);
        tick_in = 1'b0;
        @(negedge clk);
        chk("wrap oneshot0", {31'h0, wrap_pulse0}, 32'h0);
        chk("wrap oneshot1", {31'h0, wrap_pulse1}, 32'h0);
        tick_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("sat disp1", {8'h0, disp1}, {8'h0, 24'h595999});
        chk("sat pulse1", {31'h0, wrap_pulse1}, 32'h1);
        chk("post-wrap disp0", {8'h0, disp0}, {8'h0, 24'h000001});
        chk("post-wrap pulse0", {31'h0, wrap_pulse0}, 32'h0);
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("wrap counts", wp0 * 16 + wp1, 1 * 16 + 2);

        // Clear coincident with a rise while in HOLD
        preload(24'h030745);
        pulse_lap();
        chk_both("hold 03:07.45", 24'h030745, 1'b1);
        tick_in = 1'b1; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        chk_both("clear+rise", 24'h000000, 1'b0);
        chk("clear wrap0", {31'h0, wrap_pulse0}, 32'h0);
        tick_in = 1'b0;
        @(negedge clk);
        rises(1, 3, 3);
        chk_both("rise after clear", 24'h000001, 1'b0);

        // Level held high counts once
        pulse_clear();
        tick_in = 1'b1;
        repeat (20) @(negedge clk);
        chk_both("held high", 24'h000001, 1'b0);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_both("held high released", 24'h000001, 1'b0);

        // Async reset mid-HOLD with tick_in high
        rises(7, 3, 3);
        pulse_lap();
        tick_in = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_both("async reset", 24'h000000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk_both("no count after reset", 24'h000000, 1'b0);
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
        rises(1, 3, 3);
        chk_both("count after re-rise", 24'h000001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
